// File: rtl/clock_ctrl_pkg.sv
// Shared mode encodings for the digital-clock set controller.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'b00,
        MODE_SET_SEC  = 2'b01,
        MODE_SET_MIN  = 2'b10,
        MODE_SET_HOUR = 2'b11
    } mode_t;

endpackage

// File: rtl/btn_repeat.sv
// Rising-edge detector plus hold counter producing single-cycle step requests
// with auto-repeat for one up/down button.
module btn_repeat #(
    parameter int HOLD_TICKS = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    input  logic tick_5hz,
    input  logic enable,
    input  logic clear,
    output logic req,
    output logic rise
);

    localparam logic [2:0] HOLD_LAST = 3'(HOLD_TICKS - 1);

    logic       prev;
    logic [2:0] hold;
    logic       repeat_hit;

    // prev resets high so a button held through reset release gives no edge
    assign rise       = level & ~prev;
    assign repeat_hit = level & tick_5hz & ~rise & (hold >= HOLD_LAST);
    assign req        = enable & ~clear & (rise | repeat_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= 1'b1;
            hold <= '0;
        end else begin
            prev <= level;
            if (!enable || clear || !level || rise) begin
                hold <= '0;
            end else if (tick_5hz && (hold < HOLD_LAST)) begin
                hold <= hold + 3'd1;
            end
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode FSM, up/down strobe arbitration, inactivity timeout and blink control
// for the digital clock's time-setting buttons.
module clock_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int TIMEOUT_SEC = 30,
    parameter int HOLD_TICKS  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_5hz,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_dw,
    output logic [1:0] select_mode,
    output logic       ena_up,
    output logic       ena_dw,
    output logic       blink
);

    localparam logic [5:0] TIMEOUT_LAST = 6'(TIMEOUT_SEC - 1);

    mode_t      state;
    mode_t      state_next;
    logic       mode_prev;
    logic       tick5_prev;
    logic       lock_up;
    logic       lock_dw;
    logic [5:0] idle_cnt;

    logic mode_edge;
    logic tick5;
    logic set_mode;
    logic both;
    logic clr_up;
    logic clr_dw;
    logic req_up;
    logic req_dw;
    logic rise_up;
    logic rise_dw;
    logic any_edge;
    logic timeout;

    assign mode_edge = btn_mode & ~mode_prev;
    assign tick5     = tick_5hz & ~tick5_prev;
    assign set_mode  = (state != MODE_RUN);
    assign both      = btn_up & btn_dw;

    // A button left held after an up+dw overlap stays muted until released
    assign clr_up = both | mode_edge | lock_up;
    assign clr_dw = both | mode_edge | lock_dw;

    btn_repeat #(.HOLD_TICKS(HOLD_TICKS)) u_up (
        .clk      (clk),
        .rst      (rst),
        .level    (btn_up),
        .tick_5hz (tick5),
        .enable   (set_mode),
        .clear    (clr_up),
        .req      (req_up),
        .rise     (rise_up)
    );

    btn_repeat #(.HOLD_TICKS(HOLD_TICKS)) u_dw (
        .clk      (clk),
        .rst      (rst),
        .level    (btn_dw),
        .tick_5hz (tick5),
        .enable   (set_mode),
        .clear    (clr_dw),
        .req      (req_dw),
        .rise     (rise_dw)
    );

    assign any_edge = mode_edge | rise_up | rise_dw;
    assign timeout  = set_mode & tick_1hz & ~any_edge & (idle_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MODE_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (mode_edge) begin
            case (state)
                MODE_RUN:      state_next = MODE_SET_HOUR;
                MODE_SET_HOUR: state_next = MODE_SET_MIN;
                MODE_SET_MIN:  state_next = MODE_SET_SEC;
                default:       state_next = MODE_RUN;
            endcase
        end else if (timeout) begin
            state_next = MODE_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_prev  <= 1'b1;
            tick5_prev <= 1'b0;
            lock_up    <= 1'b0;
            lock_dw    <= 1'b0;
            idle_cnt   <= '0;
            blink      <= 1'b0;
            ena_up     <= 1'b0;
            ena_dw     <= 1'b0;
        end else begin
            mode_prev  <= btn_mode;
            tick5_prev <= tick_5hz;
            lock_up    <= btn_up & (both | lock_up);
            lock_dw    <= btn_dw & (both | lock_dw);
            ena_up     <= req_up & ~req_dw;
            ena_dw     <= req_dw & ~req_up;

            if (!set_mode || any_edge || timeout) begin
                idle_cnt <= '0;
            end else if (tick_1hz) begin
                idle_cnt <= idle_cnt + 6'd1;
            end

            // Every mode change restarts the blink phase with the field visible
            if ((state_next == MODE_RUN) || (state_next != state)) begin
                blink <= 1'b0;
            end else if (tick5) begin
                blink <= ~blink;
            end
        end
    end

    assign select_mode = state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with default TIMEOUT_SEC=30, HOLD_TICKS=3.
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       tick_5hz = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_dw = 1'b0;
    logic [1:0] select_mode;
    logic       ena_up;
    logic       ena_dw;
    logic       blink;

    int total = 0;
    int bad = 0;
    int up_cnt = 0;
    int dw_cnt = 0;
    int both_cnt = 0;
    int base_up;
    int base_dw;

    clock_set_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .tick_1hz    (tick_1hz),
        .tick_5hz    (tick_5hz),
        .btn_mode    (btn_mode),
        .btn_up      (btn_up),
        .btn_dw      (btn_dw),
        .select_mode (select_mode),
        .ena_up      (ena_up),
        .ena_dw      (ena_dw),
        .blink       (blink)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ena_up) up_cnt++;
        if (ena_dw) dw_cnt++;
        if (ena_up && ena_dw) both_cnt++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic t5(input int w);
        tick_5hz = 1'b1;
        cyc(w);
        tick_5hz = 1'b0;
        cyc(3);
    endtask

    task automatic t1();
        tick_1hz = 1'b1;
        cyc(1);
        tick_1hz = 1'b0;
        cyc(1);
    endtask

    task automatic mode_press();
        btn_mode = 1'b1;
        cyc(1);
        btn_mode = 1'b0;
        cyc(1);
    endtask

    initial begin
        cyc(2);
        chk("rst_mode", select_mode, 0);
        chk("rst_up", ena_up, 0);
        chk("rst_dw", ena_dw, 0);
        chk("rst_blink", blink, 0);
        rst = 1'b0;
        cyc(2);

        // mode sequence RUN -> HOUR -> MIN -> SEC -> RUN
        base_up = up_cnt; base_dw = dw_cnt;
        mode_press(); chk("seq_hour", select_mode, 3);
        mode_press(); chk("seq_min", select_mode, 2);
        mode_press(); chk("seq_sec", select_mode, 1);
        mode_press(); chk("seq_run", select_mode, 0);
        chk("seq_no_strobe", (up_cnt - base_up) + (dw_cnt - base_dw), 0);

        // SET_MIN: blink toggling, wide tick toggles once
        mode_press(); mode_press();
        chk("min_sel", select_mode, 2);
        chk("blink_entry", blink, 0);
        t5(1); chk("blink_t1", blink, 1);
        t5(1); chk("blink_t2", blink, 0);
        t5(1); chk("blink_t3", blink, 1);
        t5(3); chk("blink_wide", blink, 0);

        // single press: strobe one cycle after sample edge, one cycle wide
        btn_up = 1'b1;
        cyc(1);
        chk("up_lat", ena_up, 1);
        btn_up = 1'b0;
        cyc(1);
        chk("up_width", ena_up, 0);
        cyc(2);

        // hold for 10 ticks (mixed widths): 1 edge + 8 repeats
        base_up = up_cnt; base_dw = dw_cnt;
        btn_up = 1'b1;
        cyc(1);
        for (int i = 0; i < 10; i++) t5((i % 2 == 1) ? 2 : 1);
        btn_up = 1'b0;
        cyc(2);
        chk("hold_up_cnt", up_cnt - base_up, 9);
        chk("hold_dw_cnt", dw_cnt - base_dw, 0);
        chk("blink_after_hold", blink, 0);
        t5(1);
        chk("blink_pre_mode", blink, 1);
        mode_press();
        chk("mode_to_sec", select_mode, 1);
        chk("blink_mode_clr", blink, 0);
        mode_press();
        chk("back_run", select_mode, 0);

        // RUN ignores held dw
        base_dw = dw_cnt;
        btn_dw = 1'b1;
        cyc(1);
        for (int i = 0; i < 10; i++) t5(1);
        btn_dw = 1'b0;
        cyc(2);
        chk("run_dw_cnt", dw_cnt - base_dw, 0);
        chk("run_blink", blink, 0);

        // SET_SEC: up+dw together, then up left held stays muted
        mode_press(); mode_press(); mode_press();
        chk("sec_sel", select_mode, 1);
        base_up = up_cnt; base_dw = dw_cnt;
        btn_up = 1'b1; btn_dw = 1'b1;
        cyc(1);
        for (int i = 0; i < 4; i++) t5(1);
        btn_dw = 1'b0;
        cyc(1);
        for (int i = 0; i < 5; i++) t5(1);
        btn_up = 1'b0;
        cyc(2);
        chk("both_up_cnt", up_cnt - base_up, 0);
        chk("both_dw_cnt", dw_cnt - base_dw, 0);
        btn_up = 1'b1;
        cyc(1);
        btn_up = 1'b0;
        cyc(2);
        chk("fresh_up_cnt", up_cnt - base_up, 1);

        // mode edge and up edge together: mode wins, strobe dropped
        base_up = up_cnt;
        btn_mode = 1'b1; btn_up = 1'b1;
        cyc(1);
        chk("conf_up", ena_up, 0);
        chk("conf_sel", select_mode, 0);
        btn_mode = 1'b0; btn_up = 1'b0;
        cyc(2);
        chk("conf_up_cnt", up_cnt - base_up, 0);

        // timeout after 30 idle seconds in SET_HOUR
        mode_press();
        chk("to_hour", select_mode, 3);
        for (int i = 0; i < 29; i++) t1();
        chk("to_29", select_mode, 3);
        tick_1hz = 1'b1;
        cyc(1);
        chk("to_30", select_mode, 0);
        tick_1hz = 1'b0;
        cyc(1);

        // press at tick 20 restarts count: timeout lands at tick 50
        mode_press();
        for (int i = 0; i < 19; i++) t1();
        tick_1hz = 1'b1; btn_up = 1'b1;
        cyc(1);
        tick_1hz = 1'b0; btn_up = 1'b0;
        cyc(1);
        for (int i = 0; i < 29; i++) t1();
        chk("to_49", select_mode, 3);
        tick_1hz = 1'b1;
        cyc(1);
        chk("to_50", select_mode, 0);
        tick_1hz = 1'b0;
        cyc(1);

        // edge on the terminal tick wins
        mode_press();
        for (int i = 0; i < 29; i++) t1();
        tick_1hz = 1'b1; btn_dw = 1'b1;
        cyc(1);
        chk("to_edge_wins", select_mode, 3);
        tick_1hz = 1'b0; btn_dw = 1'b0;
        cyc(1);
        for (int i = 0; i < 29; i++) t1();
        chk("to_edge_29", select_mode, 3);
        t1();
        chk("to_edge_30", select_mode, 0);

        // reset mid-repeat in SET_SEC with up held
        mode_press(); mode_press(); mode_press();
        chk("rr_sel", select_mode, 1);
        base_up = up_cnt;
        btn_up = 1'b1;
        cyc(1);
        for (int i = 0; i < 4; i++) t5(1);
        chk("rr_repeat_cnt", up_cnt - base_up, 3);
        tick_5hz = 1'b1;
        rst = 1'b1;
        #1;
        chk("rr_sel_rst", select_mode, 0);
        chk("rr_up_rst", ena_up, 0);
        chk("rr_blink_rst", blink, 0);
        cyc(2);
        tick_5hz = 1'b0;
        rst = 1'b0;
        base_up = up_cnt;
        cyc(1);
        chk("rr_up_after", ena_up, 0);
        for (int i = 0; i < 5; i++) t5(1);
        btn_up = 1'b0;
        cyc(2);
        chk("rr_up_cnt", up_cnt - base_up, 0);
        chk("rr_sel_after", select_mode, 0);

        chk("exclusive", both_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Mode and set-button controller for the digital clock. Turns the three debounced user buttons into the `select_mode` code and single-cycle `ena_up`/`ena_dw` increment/decrement strobes that drive the seconds, minutes and hours counters. It adds auto-repeat on held buttons, a blink enable for the field being edited, and an inactivity timeout that returns to run mode. Sits between the button debouncers and the `count_*` counter blocks.

## Interface
Parameters:
- `TIMEOUT_SEC`, default 30: seconds of no button activity in a set mode before returning to RUN; range 1–63.
- `HOLD_TICKS`, default 3: `tick_5hz` pulses a button must be held before auto-repeat starts; range 1–7.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tick_1hz`  in  1  one-cycle pulse, once per second.
- `tick_5hz`  in  1  one-cycle pulse, five times per second.
- `btn_mode`  in  1  debounced, synchronized level; 1 = pressed.
- `btn_up`  in  1  debounced level; 1 = pressed.
- `btn_dw`  in  1  debounced level; 1 = pressed.
- `select_mode`  out  2  00 RUN, 01 SET_SEC, 10 SET_MIN, 11 SET_HOUR.
- `ena_up`  out  1  one-cycle increment strobe for the selected field.
- `ena_dw`  out  1  one-cycle decrement strobe for the selected field.
- `blink`  out  1  1 = blank the selected field on the display.

## Operation
- Mode FSM: RUN → SET_HOUR → SET_MIN → SET_SEC → RUN, advancing on each rising edge of `btn_mode`. `select_mode` always equals the state code.
- Edge detection:
  - Compares each button against its registered previous value.
  - The previous-value registers reset to 1, so a button held through reset release generates no edge.
- Up/down buttons in set modes:
  - A rising edge produces one strobe.
  - While the button stays held, count `tick_5hz` pulses. On the `HOLD_TICKS`-th pulse and every pulse after it, emit one strobe per `tick_5hz`.
  - Release clears the hold count.
- RUN mode: `btn_up`/`btn_dw` are ignored and produce no strobes. Hold counters stay at 0.
- Conflicts:
  - `btn_up` and `btn_dw` both high: no strobes, and both hold counts clear. A strobe resumes only on a fresh rising edge after the other button is released.
  - A `btn_mode` edge in the same cycle as an up/dw edge: the mode advance wins, the up/dw strobe is dropped, and the hold counts clear.
- `ena_up` and `ena_dw` are never high in the same cycle.
- Timeout:
  - A 6-bit counter clears on any button rising edge and on entry to a set mode.
  - It increments on `tick_1hz` while in a set mode.
  - When it reaches `TIMEOUT_SEC`, the state returns to RUN and the counter clears.
  - A button edge in the same cycle as the terminal tick wins: the counter clears and the state stays.
- Blink:
  - In set modes, `blink` toggles on each `tick_5hz` (2.5 Hz square wave).
  - It is forced to 0 in RUN and cleared on every mode change, so each newly selected field starts visible.

## Timing
- Reset values: `select_mode`=00, `ena_up`=0, `ena_dw`=0, `blink`=0. Hold and timeout counters 0. Previous-button registers 1.
- All outputs are registered. A button edge sampled at rising edge N changes `select_mode` or pulses a strobe during cycle N+1.
- Strobes are exactly one `clk` cycle wide. This holds even when `tick_5hz` is wider than one cycle; the block acts only on the first cycle in which `tick_5hz` is high.
- `tick_5hz` and a button edge in the same cycle: the edge strobe is emitted and the tick does not count toward the hold.
- Reset asserted mid-repeat or mid-set: all state returns to reset values immediately, with no strobe in the cycle after release.

## Structure
- Package `clock_ctrl_pkg` holds:
  - the mode encodings `MODE_RUN`, `MODE_SET_SEC`, `MODE_SET_MIN`, `MODE_SET_HOUR`;
  - the 2-bit mode typedef.
- Sub-module `btn_repeat`, instantiated twice (up, dw):
  - inputs: `clk`, `rst`, level, `tick_5hz`, enable, clear;
  - output: a one-cycle request;
  - contains the edge detector and the hold counter.
- The top level holds the mode FSM, conflict resolution, timeout counter and blink register.

## Test plan
- Reset, then three `btn_mode` presses → `select_mode` goes 11, 10, 01; a fourth press → 00. No `ena_up`/`ena_dw` strobes at any point.
- In SET_MIN, press `btn_up` for 1 cycle → one `ena_up` pulse, one cycle after the sample edge. Held for 10 `tick_5hz` pulses with `HOLD_TICKS`=3 → 1 + 8 = 9 total `ena_up` pulses.
- In RUN, hold `btn_dw` for 10 `tick_5hz` pulses → zero `ena_dw` pulses. Then `btn_up` and `btn_dw` held together in SET_SEC → zero strobes.
- Enter SET_HOUR, apply no buttons, `TIMEOUT_SEC`=30 → `select_mode`=00 right after the 30th `tick_1hz`. A `btn_up` press at the 20th tick restarts the count, so the timeout lands at tick 50.
- Assert `rst` mid-repeat in SET_SEC while `btn_up` stays held → all outputs at reset values. No `ena_up` after release until a new press.
- `blink`: in SET_MIN it toggles on each `tick_5hz`. A `btn_mode` press forces it to 0; in RUN it stays 0.
